// File: rtl/sink_vc_drain_scheduler.sv
// rtl/sink_vc_drain_scheduler.sv - paced, packet-atomic drain scheduler for a sink-port flit buffer
// Optional statistics outputs compiled in with `define SINK_SCHED_STATS_EN.
module sink_vc_drain_scheduler #(
  parameter  int num_vcs      = 8,
  parameter  int buffer_size  = 64,
  parameter  int consume_rate = 10000,
  localparam int depth        = buffer_size / num_vcs,
  localparam int vc_idx_width = (num_vcs > 1) ? $clog2(num_vcs) : 1,
  localparam int occ_width    = $clog2(depth + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_push_valid,
  input  logic [num_vcs-1:0]      i_push_sel_ivc,
  input  logic [num_vcs-1:0]      i_pop_tail_ivc,
  output logic                    o_pop_valid,
  output logic [num_vcs-1:0]      o_pop_sel_ivc,
  output logic                    o_fc_valid,
  output logic [vc_idx_width-1:0] o_fc_vc,
  output logic                    o_error
`ifdef SINK_SCHED_STATS_EN
  ,
  output logic [31:0]             o_pkt_count,
  output logic [31:0]             o_stall_count
`endif
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [14:0]          rate_q   = 15'(consume_rate);
  localparam logic [14:0]          unit_q   = 15'd10000;
  localparam logic [occ_width-1:0] depth_q  = occ_width'(depth);
  localparam logic [vc_idx_width-1:0] last_vc_q = vc_idx_width'(num_vcs - 1);

  logic [occ_width-1:0]    r_occ [num_vcs];
  logic [14:0]             r_acc;
  logic [vc_idx_width-1:0] r_ptr;
  logic [vc_idx_width-1:0] r_lock_vc;
  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_fc_valid;
  logic [vc_idx_width-1:0] r_fc_vc;
  logic                    r_error;

  logic [num_vcs-1:0]      w_req;
  logic [num_vcs-1:0]      w_full;
  logic [num_vcs-1:0]      w_inc;
  logic [num_vcs-1:0]      w_dec;
  logic [14:0]             w_acc_sum;
  logic                    w_token;
  logic                    w_rr_found;
  logic [vc_idx_width-1:0] w_rr_idx;
  logic [vc_idx_width-1:0] w_scan_idx;
  logic [vc_idx_width-1:0] w_grant_idx;
  logic                    w_grant_ok;
  logic                    w_grant_tail;
  logic                    w_pop;
  logic [vc_idx_width-1:0] w_next_ptr;
  logic                    w_overflow;
  logic                    w_underflow;

  always_comb begin
    for (int v = 0; v < num_vcs; v++) begin
      w_req[v]  = (r_occ[v] != '0);
      w_full[v] = (r_occ[v] == depth_q);
    end
  end

  // Accumulator never exceeds 10000 and rate is at most 10000, so 15 bits cannot overflow.
  assign w_acc_sum = r_acc + rate_q;
  assign w_token   = (w_acc_sum >= unit_q);

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_scan_idx = '0;
    for (int i = 0; i < num_vcs; i++) begin
      w_scan_idx = vc_idx_width'((int'(r_ptr) + i) % num_vcs);
      if (!w_rr_found && w_req[w_scan_idx]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_scan_idx;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_pop && !w_grant_tail) w_state_next = ST_LOCKED;
      ST_LOCKED: if (w_pop && w_grant_tail)  w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs - while locked only the locked VC may pop, even when it is empty.
  always_comb begin
    w_grant_idx   = w_rr_idx;
    w_grant_ok    = w_rr_found;
    if (r_state == ST_LOCKED) begin
      w_grant_idx = r_lock_vc;
      w_grant_ok  = w_req[r_lock_vc];
    end
    w_grant_tail  = i_pop_tail_ivc[w_grant_idx];
    w_pop         = w_token && w_grant_ok;
    o_pop_valid   = w_pop;
    o_pop_sel_ivc = '0;
    if (w_pop) o_pop_sel_ivc[w_grant_idx] = 1'b1;
  end

  assign w_next_ptr = (w_grant_idx == last_vc_q) ? '0 : w_grant_idx + vc_idx_width'(1);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr     <= '0;
      r_lock_vc <= '0;
    end else if (w_pop) begin
      if (r_state == ST_IDLE || w_grant_tail) r_ptr <= w_next_ptr;
      if (r_state == ST_IDLE && !w_grant_tail) r_lock_vc <= w_grant_idx;
    end
  end

  // Unused budget saturates at a single pending pop.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_acc <= '0;
    end else if (w_token && w_pop) begin
      r_acc <= w_acc_sum - unit_q;
    end else if (w_token) begin
      r_acc <= unit_q;
    end else begin
      r_acc <= w_acc_sum;
    end
  end

  assign w_inc       = i_push_valid ? i_push_sel_ivc : '0;
  assign w_dec       = o_pop_sel_ivc;
  assign w_overflow  = |(w_inc & ~w_dec & w_full);
  assign w_underflow = |(w_dec & ~w_inc & ~w_req);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int v = 0; v < num_vcs; v++) r_occ[v] <= '0;
    end else begin
      for (int v = 0; v < num_vcs; v++) begin
        if (w_inc[v] && !w_dec[v] && !w_full[v]) begin
          r_occ[v] <= r_occ[v] + occ_width'(1);
        end else if (!w_inc[v] && w_dec[v] && w_req[v]) begin
          r_occ[v] <= r_occ[v] - occ_width'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_error <= 1'b0;
    end else if (w_overflow || w_underflow) begin
      r_error <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fc_valid <= 1'b0;
      r_fc_vc    <= '0;
    end else begin
      r_fc_valid <= w_pop;
      if (w_pop) r_fc_vc <= w_grant_idx;
    end
  end

  assign o_fc_valid = r_fc_valid;
  assign o_fc_vc    = r_fc_vc;
  assign o_error    = r_error;

`ifdef SINK_SCHED_STATS_EN
  logic [31:0] r_pkt_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pkt_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_pop && w_grant_tail) r_pkt_count <= r_pkt_count + 32'd1;
      if ((|w_req) && !w_pop)    r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign o_pkt_count   = r_pkt_count;
  assign o_stall_count = r_stall_count;
`endif

endmodule
